// File: rtl/spi_link_scheduler_if.sv
// Bundles the client-side request/response signals and the serial-link pins of one scheduler.
// Latency: none, wiring only.
// Backpressure: req is a level held by the client until its grant pulse; no other flow control.
interface spi_link_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rx_data;
    logic                      busy;
    logic                      ss;
    logic                      sclk;
    logic                      MOSI;
    logic                      MISO;

    // Scheduler side: drives grants, completion and the link pins.
    modport master (
        input  req, req_data, MISO,
        output grant, done, rx_data, busy, ss, sclk, MOSI
    );

    // Client / link-partner side.
    modport slave (
        output req, req_data, MISO,
        input  grant, done, rx_data, busy, ss, sclk, MOSI
    );
endinterface

// File: rtl/spi_link_scheduler.sv
// Round-robin scheduler sharing one mode-0 serial master link between NUM_REQ clients.
// Latency: grant on the first IDLE edge with req high; done 2*CLK_DIV*DATA_W cycles after grant.
// Backpressure: req must be held until grant; requests wait while a frame or inter-frame gap runs.
module spi_link_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2,
    parameter int GAP     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_link_scheduler_if.master bus
);
    localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [IW-1:0]    LAST_REQ = IW'(NUM_REQ - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t            state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     owner;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DATA_W-2:0] tx_rest;   // bits still to send after the one on MOSI
    logic [DATA_W-1:0] rx_shift;

    logic              win_vld;
    logic [IW-1:0]     win_idx;
    logic [IW-1:0]     cand_idx;
    logic [DATA_W-1:0] win_word;
    int                cand;

    // Pick the first requester at or above ptr (wrapping) and select its data word.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        win_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IW'(cand);
            if (!win_vld && bus.req[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IW'(i)) begin
                win_word = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Link FSM: arbitrate in IDLE, shift one full-duplex frame, then hold ss low for the gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            owner        <= '0;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            gap_cnt      <= '0;
            tx_rest      <= '0;
            rx_shift     <= '0;
            bus.grant    <= '0;
            bus.done     <= '0;
            bus.rx_data  <= '0;
            bus.busy     <= 1'b0;
            bus.ss       <= 1'b0;
            bus.sclk     <= 1'b0;
            bus.MOSI     <= 1'b0;
        end else begin
            bus.grant <= '0;
            bus.done  <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        bus.grant[win_idx] <= 1'b1;
                        owner              <= win_idx;
                        tx_rest            <= win_word[DATA_W-2:0];
                        bus.MOSI           <= win_word[DATA_W-1];
                        bus.ss             <= 1'b1;
                        bus.sclk           <= 1'b0;
                        bus.busy           <= 1'b1;
                        bit_cnt            <= '0;
                        div_cnt            <= '0;
                        ptr                <= (win_idx == LAST_REQ) ? '0 : win_idx + 1'b1;
                        state              <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt == LAST_DIV) begin
                        div_cnt <= '0;
                        if (!bus.sclk) begin
                            // Rising sclk: partner data has been stable for a full low phase.
                            bus.sclk <= 1'b1;
                            rx_shift <= {rx_shift[DATA_W-2:0], bus.MISO};
                        end else if (bit_cnt == LAST_BIT) begin
                            // Last falling sclk closes the frame and releases the link.
                            bus.sclk        <= 1'b0;
                            bus.ss          <= 1'b0;
                            bus.MOSI        <= 1'b0;
                            bus.done[owner] <= 1'b1;
                            bus.rx_data     <= rx_shift;
                            gap_cnt         <= '0;
                            if (GAP == 0) begin
                                bus.busy <= 1'b0;
                                state    <= ST_IDLE;
                            end else begin
                                state    <= ST_GAP;
                            end
                        end else begin
                            bus.sclk <= 1'b0;
                            bus.MOSI <= tx_rest[DATA_W-2];
                            tx_rest  <= tx_rest << 1;
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == LAST_GAP) begin
                        bus.busy <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_link_scheduler.sv
// Self-checking bench: two schedulers (GAP=2 and GAP=0) driven by shared stimulus.
// Latency: each output is compared every cycle against a frame-level reference model.
// Backpressure: requesters drop req on grant unless a scenario holds it deliberately.
module tb_spi_link_scheduler;
    localparam int NR    = 4;
    localparam int DW    = 8;
    localparam int CD    = 2;
    localparam int GAP0  = 2;
    localparam int GAP1  = 0;
    localparam int FRAME = 2 * CD * DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_link_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) bus0 ();
    spi_link_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) bus1 ();

    spi_link_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .CLK_DIV(CD), .GAP(GAP0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.master)
    );

    spi_link_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .CLK_DIV(CD), .GAP(GAP1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [NR-1:0]    req_cur;
    logic [NR*DW-1:0] data_cur;
    bit               auto_drop;
    bit               force_en;
    logic [DW-1:0]    force_word;

    // Reference model: one frame timer per instance, arithmetic round-robin pointer.
    bit            m_act  [2];
    int            m_t    [2];
    int            m_gap  [2];
    int            m_ptr  [2];
    int            m_own  [2];
    logic [DW-1:0] m_word [2];
    logic [DW-1:0] m_miso [2];
    logic [DW-1:0] e_rx   [2];
    logic [NR-1:0] e_grant[2];
    logic [NR-1:0] e_done [2];

    // Instance-0 frame monitor.
    logic [NR-1:0] g_q[$];
    logic [NR-1:0] d_q[$];
    logic [DW-1:0] w_q[$];
    logic [DW-1:0] rx_q[$];
    int            gc_q[$];
    int            dc_q[$];
    int            bf_q[$];
    int            gc1_q[$];
    int            dc1_q[$];
    int            ss_cnt;
    int            rise_cnt;
    logic          prev_sclk0;
    logic          prev_busy0;
    logic [DW-1:0] cur_bits;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int gap_of(input int k);
        return (k == 0) ? GAP0 : GAP1;
    endfunction

    // Link partner: presents the current frame's MISO word, one bit per sclk period.
    function automatic logic miso_bit(input int k);
        if (m_act[k]) begin
            return m_miso[k][DW - 1 - m_t[k] / (2 * CD)];
        end
        return 1'($urandom);
    endfunction

    task automatic model_step(input int k, input logic [NR-1:0] r,
                              input logic [NR*DW-1:0] d, input logic rs);
        int c;
        e_grant[k] = '0;
        e_done[k]  = '0;
        if (rs) begin
            m_act[k] = 1'b0;
            m_gap[k] = 0;
            m_ptr[k] = 0;
            e_rx[k]  = '0;
        end else if (m_act[k]) begin
            m_t[k]++;
            if (m_t[k] == FRAME) begin
                m_act[k]             = 1'b0;
                e_done[k][m_own[k]]  = 1'b1;
                e_rx[k]              = m_miso[k];
                m_gap[k]             = gap_of(k);
            end
        end else if (m_gap[k] > 0) begin
            m_gap[k]--;
        end else if (r != '0) begin
            for (int i = 0; i < NR; i++) begin
                c = (m_ptr[k] + i) % NR;
                if (!m_act[k] && r[c]) begin
                    m_act[k]      = 1'b1;
                    m_t[k]        = 0;
                    m_own[k]      = c;
                    m_word[k]     = d[c*DW +: DW];
                    m_miso[k]     = force_en ? force_word : DW'($urandom);
                    m_ptr[k]      = (c + 1) % NR;
                    e_grant[k][c] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_vec(input int k);
        logic sclk_e;
        logic mosi_e;
        logic busy_e;
        sclk_e = 1'b0;
        mosi_e = 1'b0;
        if (m_act[k]) begin
            sclk_e = ((m_t[k] % (2 * CD)) >= CD);
            mosi_e = m_word[k][DW - 1 - m_t[k] / (2 * CD)];
        end
        busy_e = m_act[k] || (m_gap[k] > 0);
        return {12'b0, e_grant[k], e_done[k], busy_e, m_act[k], sclk_e, mosi_e, e_rx[k]};
    endfunction

    task automatic clear_mon();
        g_q.delete(); d_q.delete(); w_q.delete(); rx_q.delete();
        gc_q.delete(); dc_q.delete(); bf_q.delete(); gc1_q.delete(); dc1_q.delete();
        ss_cnt   = 0;
        rise_cnt = 0;
    endtask

    // One clock: drive inputs, advance the model, compare both instances, record events.
    task automatic cycle(input logic rs);
        rst           = rs;
        bus0.req      = req_cur;
        bus1.req      = req_cur;
        bus0.req_data = data_cur;
        bus1.req_data = data_cur;
        bus0.MISO     = miso_bit(0);
        bus1.MISO     = miso_bit(1);
        @(posedge clk);
        #1;
        cyc++;
        model_step(0, req_cur, data_cur, rs);
        model_step(1, req_cur, data_cur, rs);
        check_eq("i0_outputs", {12'b0, bus0.grant, bus0.done, bus0.busy, bus0.ss,
                                bus0.sclk, bus0.MOSI, bus0.rx_data}, exp_vec(0));
        check_eq("i1_outputs", {12'b0, bus1.grant, bus1.done, bus1.busy, bus1.ss,
                                bus1.sclk, bus1.MOSI, bus1.rx_data}, exp_vec(1));
        if (bus0.grant != '0) begin
            g_q.push_back(bus0.grant);
            gc_q.push_back(cyc);
            cur_bits = '0;
        end
        if (bus0.ss) ss_cnt++;
        if (bus0.sclk && !prev_sclk0) begin
            rise_cnt++;
            cur_bits = {cur_bits[DW-2:0], bus0.MOSI};
        end
        if (bus0.done != '0) begin
            d_q.push_back(bus0.done);
            dc_q.push_back(cyc);
            w_q.push_back(cur_bits);
            rx_q.push_back(bus0.rx_data);
        end
        if (!bus0.busy && prev_busy0) bf_q.push_back(cyc);
        if (bus1.grant != '0) gc1_q.push_back(cyc);
        if (bus1.done != '0) dc1_q.push_back(cyc);
        prev_sclk0 = bus0.sclk;
        prev_busy0 = bus0.busy;
        if (auto_drop) req_cur = req_cur & ~bus0.grant;
    endtask

    task automatic do_reset();
        req_cur = '0;
        cycle(1'b1);
        cycle(1'b1);
        clear_mon();
    endtask

    logic [NR-1:0] exp_order [5];

    initial begin
        req_cur    = '0;
        data_cur   = '0;
        auto_drop  = 1'b1;
        force_en   = 1'b0;
        force_word = '0;
        prev_sclk0 = 1'b0;
        prev_busy0 = 1'b0;
        cur_bits   = '0;
        rst        = 1'b1;

        // Reset state.
        do_reset();
        check_eq("rst_state", {bus0.grant, bus0.done, bus0.busy, bus0.ss, bus0.sclk,
                               bus0.MOSI, bus0.rx_data}, 32'h0);

        // Single request, full-duplex frame.
        data_cur           = {$urandom};
        data_cur[1*DW +: DW] = 8'hA5;
        force_en           = 1'b1;
        force_word         = 8'h3C;
        req_cur            = 4'b0010;
        for (int n = 0; n < 80 && !(d_q.size() >= 1 && !bus0.busy); n++) cycle(1'b0);
        force_en = 1'b0;
        check_eq("t1_done_cnt", d_q.size(), 1);
        if (d_q.size() >= 1 && g_q.size() >= 1 && bf_q.size() >= 1) begin
            check_eq("t1_grant", g_q[0], 4'b0010);
            check_eq("t1_ss_cycles", ss_cnt, FRAME);
            check_eq("t1_sclk_rises", rise_cnt, DW);
            check_eq("t1_mosi_word", w_q[0], 8'hA5);
            check_eq("t1_done", d_q[0], 4'b0010);
            check_eq("t1_done_at", dc_q[0] - gc_q[0], FRAME);
            check_eq("t1_rx", rx_q[0], 8'h3C);
            check_eq("t1_busy_fall", bf_q[0] - dc_q[0], 2);
        end

        // Simultaneous requests after reset.
        do_reset();
        data_cur             = '0;
        data_cur[0*DW +: DW] = 8'h11;
        data_cur[2*DW +: DW] = 8'h33;
        req_cur              = 4'b0101;
        for (int n = 0; n < 150 && d_q.size() < 2; n++) cycle(1'b0);
        check_eq("t2_done_cnt", d_q.size(), 2);
        if (d_q.size() >= 2 && g_q.size() >= 2) begin
            check_eq("t2_first_grant", g_q[0], 4'b0001);
            check_eq("t2_first_word", w_q[0], 8'h11);
            check_eq("t2_second_grant", g_q[1], 4'b0100);
            check_eq("t2_second_word", w_q[1], 8'h33);
            check_eq("t2_spacing", gc_q[1] - dc_q[0], GAP0 + 1);
        end
        if (gc1_q.size() >= 2 && dc1_q.size() >= 1)
            check_eq("t2_gap0_spacing", gc1_q[1] - dc1_q[0], GAP1 + 1);
        else
            check_eq("t2_gap0_grants", gc1_q.size(), 2);

        // Fairness under constant load.
        do_reset();
        auto_drop = 1'b0;
        req_cur   = 4'b1111;
        for (int n = 0; n < 250 && g_q.size() < 5; n++) cycle(1'b0);
        check_eq("t3_grant_cnt", g_q.size(), 5);
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        if (g_q.size() >= 5) begin
            for (int i = 0; i < 5; i++) check_eq("t3_order", g_q[i], exp_order[i]);
            for (int i = 1; i < 5; i++) check_eq("t3_no_repeat", 32'(g_q[i] == g_q[i-1]), 0);
        end

        // Reset in the middle of a frame owned by requester 2.
        auto_drop = 1'b1;
        req_cur   = '0;
        for (int n = 0; n < 80 && (bus0.busy || bus1.busy); n++) cycle(1'b0);
        clear_mon();
        data_cur = {$urandom};
        req_cur  = 4'b0100;
        for (int n = 0; n < 10 && g_q.size() < 1; n++) cycle(1'b0);
        check_eq("t4_grant", g_q.size() >= 1 ? 32'(g_q[0]) : 32'h0, 4'b0100);
        for (int n = 0; n < 9; n++) cycle(1'b0);
        cycle(1'b1);
        check_eq("t4_after_rst", {bus0.ss, bus0.sclk, bus0.busy, bus0.done, bus0.grant,
                                  bus0.rx_data}, 32'h0);
        req_cur = 4'b1001;
        for (int n = 0; n < 10 && g_q.size() < 2; n++) cycle(1'b0);
        check_eq("t4_no_done", d_q.size(), 0);
        check_eq("t4_regrant", g_q.size() >= 2 ? 32'(g_q[1]) : 32'h0, 4'b0001);

        // Request withdrawn mid-frame.
        do_reset();
        auto_drop = 1'b0;
        req_cur   = 4'b1000;
        for (int n = 0; n < 10 && g_q.size() < 1; n++) cycle(1'b0);
        for (int n = 0; n < 4; n++) cycle(1'b0);
        req_cur = '0;
        for (int n = 0; n < 60 && (d_q.size() < 1 || dc1_q.size() < 1); n++) cycle(1'b0);
        if (d_q.size() >= 1 && gc_q.size() >= 1 && dc1_q.size() >= 1 && gc1_q.size() >= 1) begin
            check_eq("t5_done", d_q[0], 4'b1000);
            check_eq("t5_frame_len", dc_q[0] - gc_q[0], FRAME);
            check_eq("t5_gap0_frame_len", dc1_q[0] - gc1_q[0], FRAME);
        end else begin
            check_eq("t5_done_cnt", d_q.size(), 1);
        end

        // Held request: next grant timing with and without a gap.
        do_reset();
        req_cur = 4'b1000;
        for (int n = 0; n < 120 && (gc_q.size() < 2 || gc1_q.size() < 2); n++) cycle(1'b0);
        if (gc_q.size() >= 2 && dc_q.size() >= 1 && gc1_q.size() >= 2 && dc1_q.size() >= 1) begin
            check_eq("t5_regrant_gap2", gc_q[1] - dc_q[0], GAP0 + 1);
            check_eq("t5_regrant_gap0", gc1_q[1] - dc1_q[0], GAP1 + 1);
        end else begin
            check_eq("t5_regrant_cnt", gc1_q.size(), 2);
        end

        // Randomized traffic with occasional resets.
        auto_drop = 1'b1;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(7, 0) == 0) req_cur = req_cur | NR'($urandom);
            if ($urandom_range(3, 0) == 0) auto_drop = ~auto_drop;
            for (int i = 0; i < NR; i++)
                if ($urandom_range(3, 0) == 0) data_cur[i*DW +: DW] = DW'($urandom);
            cycle(($urandom_range(399, 0) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_link_scheduler.md
Name: spi_link_scheduler

Overview:
- Round-robin scheduler that shares one serial master link (ss, sclk, MOSI, MISO) between NUM_REQ requesters.
- Each accepted request becomes one DATA_W-bit full-duplex frame, sent MSB first, with ss held high for the whole frame.
- Sits between the on-chip clients and the serial-link pins, so only one client owns the link at a time.
- Returns the captured MISO word and a per-requester done pulse.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, bits per frame
CLK_DIV, 2, clk cycles per sclk half-period (>=1)
GAP, 2, idle clk cycles with ss low between frames (0 allowed)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-high
req  input  NUM_REQ  per-requester request level; hold high until grant
req_data  input  NUM_REQ*DATA_W  requester i word at [i*DATA_W +: DATA_W]
grant  output  NUM_REQ  one-hot, one-cycle pulse when a frame is accepted
done  output  NUM_REQ  one-hot, one-cycle pulse at the end of the owner's frame
rx_data  output  DATA_W  MISO word of the last completed frame; valid when any done bit is high
busy  output  1  high whenever the state is not IDLE
ss  output  1  slave select, high during a frame
sclk  output  1  serial clock, idles low
MOSI  output  1  serial data out
MISO  input  1  serial data in

Behaviour:
- Reset (rst high at a posedge, dominant over everything):
  - State goes to IDLE.
  - ss, sclk, MOSI, busy, grant and done all go to 0; rx_data goes to 0.
  - The round-robin pointer resets so requester 0 has top priority.
  - A frame in progress is abandoned with no done pulse.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - Outputs ss=0 and sclk=0.
  - On a posedge with any req bit high, the winner is the first set bit searching from ptr upward, wrapping modulo NUM_REQ.
  - At that same edge the block:
    - sets grant[winner] high for exactly one cycle;
    - latches the winner's req_data slice into the shift register and records the owner;
    - sets ss=1, MOSI=word MSB and busy=1, and moves to SHIFT;
    - sets ptr = winner+1 (mod NUM_REQ).
- SHIFT (mode 0):
  - Each bit spends CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1.
  - On the edge where sclk rises, MISO is sampled into the receive register, MSB first.
  - On the edge where sclk falls, MOSI advances to the next bit.
  - ss stays high for exactly 2*CLK_DIV*DATA_W cycles.
  - After the high phase of bit DATA_W-1, on a single edge the block:
    - returns sclk to 0 and sets ss=0 and MOSI=0;
    - pulses done[owner] for one cycle;
    - loads rx_data with the received word;
    - moves to GAP, or to IDLE if GAP=0.
  - rx_data holds its value until the next completed frame.
- GAP: ss=0 and busy=1 for GAP cycles, then IDLE. req is not evaluated during GAP.
- Arbitration is evaluated only in IDLE. Because the pointer advances past the last owner, continuously held requests are served in cyclic order.
- req changes after grant are ignored: the frame always completes. A requester still holding req after done is re-eligible at its round-robin turn.
- req_data is captured only at grant and may change afterwards.
- There is never more than one grant bit or done bit high at once.
- The minimum period between grants is 2*CLK_DIV*DATA_W + GAP + 1 cycles, with 1 IDLE cycle for arbitration.

Test Plan:
All tests use NUM_REQ=4, DATA_W=8, CLK_DIV=2, GAP=2.
- Single request, full-duplex frame: req[1]=1, slice 1 = 0xA5, MISO driven 0x3C MSB first on sclk falling edges -> grant=0010 for 1 cycle; ss high for 32 cycles; 8 sclk rising edges; MOSI bits 1,0,1,0,0,1,0,1; done=0010 on the edge ss falls; rx_data=0x3C; busy low 2 cycles later.
- Simultaneous requests after reset: req=0101 with words 0x11/0x33 -> requester 0 is served first (MOSI 0x11), then ss is low for 2 GAP cycles plus 1 IDLE cycle, then grant=0100 and MOSI 0x33.
- Fairness under constant load: req=1111 held high -> grants in order 0001, 0010, 0100, 1000, 0001, and no requester is granted twice in a row.
- Reset mid-frame: rst pulsed on cycle 10 of a frame owned by requester 2 -> next edge gives ss=0, sclk=0, busy=0, rx_data=0; no done pulse. With req=1001 afterwards, requester 0 is granted first.
- Request withdrawn mid-frame: req[3] dropped at cycle 5 of its frame -> the frame still runs 32 cycles and done=1000 pulses. Repeat with GAP=0 -> IDLE is entered the cycle after done, and the next grant follows one cycle later.
